// File: rtl/nonce_scheduler_if.sv
// ---------------------------------------------------------------------------
// nonce_scheduler_if
//   Connects the nonce scheduler to the pipelined hash core.
//   The issue side is a valid/ready handshake: a nonce is handed over when
//   core_valid and core_ready are both high on a rising edge.
//   The result side is a plain strobe. The core returns at most one result
//   per cycle, and each result carries the nonce that produced it.
//
//   Signals
//     core_valid  scheduler -> core  nonce offered
//     core_nonce  scheduler -> core  nonce value offered
//     core_ready  core -> scheduler  core can accept this cycle
//     res_valid   core -> scheduler  result strobe
//     res_hash    core -> scheduler  result hash
//     res_nonce   core -> scheduler  nonce that produced res_hash
//
//   Modports
//     master  scheduler side
//     slave   hash core side
// ---------------------------------------------------------------------------
interface nonce_scheduler_if #(
    parameter int NONCE_W = 32,
    parameter int HASH_W  = 256
) ();
    logic               core_valid;
    logic [NONCE_W-1:0] core_nonce;
    logic               core_ready;
    logic               res_valid;
    logic [HASH_W-1:0]  res_hash;
    logic [NONCE_W-1:0] res_nonce;

    modport master (
        output core_valid,
        output core_nonce,
        input  core_ready,
        input  res_valid,
        input  res_hash,
        input  res_nonce
    );

    modport slave (
        input  core_valid,
        input  core_nonce,
        output core_ready,
        output res_valid,
        output res_hash,
        output res_nonce
    );
endinterface

// File: rtl/nonce_scheduler.sv
// ---------------------------------------------------------------------------
// nonce_scheduler
//   Drives the pipelined hash core while the hashing phase is active.
//   It offers consecutive nonces, starting from 0, and keeps track of how
//   many jobs are in flight inside the core. Every returned hash is compared
//   against target. The first winning nonce is latched, and the number of
//   completed hashes is counted.
//   Issuing stops on any of these events:
//     - second_tick
//     - an abort (hash_enable dropped)
//     - a find (when STOP_ON_FIND is set)
//     - the accept of the last nonce
//   After issuing stops, the core is drained and done is raised.
//
//   Ports
//     clk          clock, rising edge
//     rst_i        synchronous active-high reset
//     hash_enable  hashing phase active; dropping it aborts a run
//     second_tick  one-cycle pulse that ends the issue phase
//     target       a result wins when res_hash < target (unsigned)
//     core_if      issue handshake and result bus toward the core (master)
//     busy         run in progress (not IDLE)
//     done         run finished, held until hash_enable drops
//     found        a winning result was seen in this run
//     found_nonce  first winning nonce of this run
//     hash_count   results received in this run (saturating)
// ---------------------------------------------------------------------------
module nonce_scheduler #(
    parameter int NONCE_W      = 32,
    parameter int HASH_W       = 256,
    parameter int PIPE_DEPTH   = 64,
    parameter int CNT_W        = 32,
    parameter int STOP_ON_FIND = 1
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic                hash_enable,
    input  logic                second_tick,
    input  logic [HASH_W-1:0]   target,
    nonce_scheduler_if.master   core_if,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic [NONCE_W-1:0]  found_nonce,
    output logic [CNT_W-1:0]    hash_count
);

    localparam int              IF_W    = $clog2(PIPE_DEPTH + 1);
    localparam logic [IF_W-1:0] DEPTH_C = IF_W'(PIPE_DEPTH);
    localparam logic            STOP_C  = (STOP_ON_FIND != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             state_q,       state_d;
    logic [NONCE_W-1:0] nonce_q,       nonce_d;
    logic [IF_W-1:0]    inflight_q,    inflight_d;
    logic [CNT_W-1:0]   hash_count_q,  hash_count_d;
    logic               found_q,       found_d;
    logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;

    logic core_valid_c;
    logic accept_c;
    logic res_take_c;
    logic win_c;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            nonce_q       <= '0;
            inflight_q    <= '0;
            hash_count_q  <= '0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
        end else begin
            state_q       <= state_d;
            nonce_q       <= nonce_d;
            inflight_q    <= inflight_d;
            hash_count_q  <= hash_count_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        nonce_d       = nonce_q;
        inflight_d    = inflight_q;
        hash_count_d  = hash_count_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;

        // Nonces are offered only while issuing and while the core has room.
        core_valid_c = (state_q == ST_ISSUE) && (inflight_q < DEPTH_C);
        accept_c     = core_valid_c && core_if.core_ready;

        // Results are used only while jobs can be outstanding. A result that
        // arrives with nothing in flight is a core fault and is dropped
        // without affecting any counter.
        res_take_c = core_if.res_valid
                     && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN))
                     && (inflight_q != '0);
        win_c      = res_take_c && (core_if.res_hash < target) && !found_q;

        if (res_take_c && (hash_count_q != {CNT_W{1'b1}})) begin
            hash_count_d = hash_count_q + 1'b1;
        end
        if (win_c) begin
            found_d       = 1'b1;
            found_nonce_d = core_if.res_nonce;
        end

        // An accept and a result in the same cycle cancel out.
        unique case ({accept_c, res_take_c})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        if (accept_c) begin
            nonce_d = nonce_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (hash_enable) begin
                    state_d       = ST_ISSUE;
                    nonce_d       = '0;
                    inflight_d    = '0;
                    hash_count_d  = '0;
                    found_d       = 1'b0;
                    found_nonce_d = '0;
                end
            end
            ST_ISSUE: begin
                // Accepting the all-ones nonce ends issuing. The counter
                // wraps to zero, but it is never offered again.
                if (second_tick
                    || !hash_enable
                    || (STOP_C && (found_q || win_c))
                    || (accept_c && (nonce_q == {NONCE_W{1'b1}}))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!hash_enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign core_if.core_valid = core_valid_c;
    assign core_if.core_nonce = nonce_q;

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign hash_count  = hash_count_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// ---------------------------------------------------------------------------
// tb_nonce_scheduler
//   Directed bench for nonce_scheduler. The DUT is built small: a 4-bit
//   nonce, depth-4 pipeline, and 16-bit hash. A behavioural core with
//   fixed latency answers every accepted nonce. Its results can be held
//   back to create backpressure.
// ---------------------------------------------------------------------------
module tb_nonce_scheduler;

    localparam int NW  = 4;
    localparam int HW  = 16;
    localparam int CW  = 8;
    localparam int PD  = 4;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          hash_enable;
    logic          second_tick;
    logic [HW-1:0] target;
    logic          busy;
    logic          done;
    logic          found;
    logic [NW-1:0] found_nonce;
    logic [CW-1:0] hash_count;

    nonce_scheduler_if #(.NONCE_W(NW), .HASH_W(HW)) bus ();

    nonce_scheduler #(
        .NONCE_W(NW), .HASH_W(HW), .PIPE_DEPTH(PD), .CNT_W(CW), .STOP_ON_FIND(1)
    ) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .hash_enable (hash_enable),
        .second_tick (second_tick),
        .target      (target),
        .core_if     (bus.master),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .found_nonce (found_nonce),
        .hash_count  (hash_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NW-1:0] nonce;
        int            due;
    } job_t;

    typedef struct {
        logic [HW-1:0] target;
        int            tick_at;     // accept count at which second_tick fires (0 = never)
        int            abort_at;    // accept count at which hash_enable drops (0 = never)
        int            win_nonce;   // nonce answered with win_hash (-1 = none)
        logic [HW-1:0] win_hash;
        int            exp_acc;
        int            exp_cnt;
        logic          exp_found;
        logic [NW-1:0] exp_fn;
    } vec_t;

    job_t          q[$];
    int            cyc;
    int            acc_count;
    int            tick_at;
    int            abort_at;
    int            win_nonce;
    logic [HW-1:0] win_hash;
    logic          hold;
    int            rel_n;
    logic          seq_err;
    int            checks;
    int            errors;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock of the behavioural core. Decisions are taken at the falling
    // edge from the DUT state, then the rising edge applies them.
    task automatic cycle();
        logic acc;
        job_t j;
        acc = bus.core_valid && bus.core_ready;
        if (acc) begin
            if (bus.core_nonce !== NW'(acc_count)) seq_err = 1'b1;
            j.nonce = bus.core_nonce;
            j.due   = cyc + LAT;
            q.push_back(j);
            acc_count++;
            if (tick_at != 0 && acc_count == tick_at) second_tick = 1'b1;
            if (abort_at != 0 && acc_count == abort_at) hash_enable = 1'b0;
        end
        if (q.size() > 0 && q[0].due <= cyc && (!hold || rel_n > 0)) begin
            j = q.pop_front();
            if (hold) rel_n--;
            bus.res_valid = 1'b1;
            bus.res_nonce = j.nonce;
            bus.res_hash  = (int'(j.nonce) == win_nonce) ? win_hash : {HW{1'b1}};
        end else begin
            bus.res_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        second_tick   = 1'b0;
        bus.res_valid = 1'b0;
    endtask

    task automatic clear_model();
        q.delete();
        acc_count = 0;
        tick_at   = 0;
        abort_at  = 0;
        win_nonce = -1;
        win_hash  = '1;
        hold      = 1'b0;
        rel_n     = 0;
        seq_err   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic got_done;
        clear_model();
        target      = v.target;
        tick_at     = v.tick_at;
        abort_at    = v.abort_at;
        win_nonce   = v.win_nonce;
        win_hash    = v.win_hash;
        hash_enable = 1'b1;
        got_done    = 1'b0;
        cycle();
        chk($sformatf("v%0d start_latency core_valid", idx), 32'(bus.core_valid), 32'd1);
        for (int c = 0; c < 100 && !got_done; c++) begin
            cycle();
            if (done) got_done = 1'b1;
        end
        chk($sformatf("v%0d done_reached", idx), 32'(got_done), 32'd1);
        chk($sformatf("v%0d accepts", idx), 32'(acc_count), 32'(v.exp_acc));
        chk($sformatf("v%0d hash_count", idx), 32'(hash_count), 32'(v.exp_cnt));
        chk($sformatf("v%0d found", idx), 32'(found), 32'(v.exp_found));
        chk($sformatf("v%0d found_nonce", idx), 32'(found_nonce), 32'(v.exp_fn));
        chk($sformatf("v%0d nonce_sequence", idx), 32'(seq_err), 32'd0);
        chk($sformatf("v%0d core_valid_in_done", idx), 32'(bus.core_valid), 32'd0);
        $display("vec %0d: accepts=%0d hash_count=%0d found=%0b found_nonce=%0d",
                 idx, acc_count, hash_count, found, found_nonce);
        if (hash_enable) begin
            cycle();
            chk($sformatf("v%0d done_holds", idx), 32'(done), 32'd1);
            chk($sformatf("v%0d count_holds", idx), 32'(hash_count), 32'(v.exp_cnt));
            hash_enable = 1'b0;
        end
        cycle();
        chk($sformatf("v%0d back_to_idle busy", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d back_to_idle done", idx), 32'(done), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        clear_model();
        rst_i          = 1'b1;
        hash_enable    = 1'b0;
        second_tick    = 1'b0;
        target         = '0;
        bus.core_ready = 1'b1;
        bus.res_valid  = 1'b0;
        bus.res_hash   = '0;
        bus.res_nonce  = '0;

        //                target  tick abort win win_hash acc cnt fnd fn
        vecs[0] = '{16'h0000, 10, 0, -1, 16'hFFFF, 10, 10, 1'b0, 4'd0};  // second_tick run
        vecs[1] = '{16'h0010,  0, 0,  5, 16'h0000,  9,  9, 1'b1, 4'd5};  // find at nonce 5
        vecs[2] = '{16'h0000,  0, 0, -1, 16'hFFFF, 16, 16, 1'b0, 4'd0};  // nonce exhaustion
        vecs[3] = '{16'h0000,  0, 6, -1, 16'hFFFF,  6,  6, 1'b0, 4'd0};  // abort
        vecs[4] = '{16'h0001,  0, 0,  2, 16'h0000,  6,  6, 1'b1, 4'd2};  // hash 0 < target 1
        vecs[5] = '{16'h0010,  8, 0,  3, 16'h0010,  8,  8, 1'b0, 4'd0};  // hash == target loses

        // Power-on reset
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_i = 1'b0;
        chk("por busy", 32'(busy), 32'd0);
        chk("por done", 32'(done), 32'd0);
        chk("por core_valid", 32'(bus.core_valid), 32'd0);
        chk("por hash_count", 32'(hash_count), 32'd0);

        // Reset mid-ISSUE with three jobs in flight
        clear_model();
        hash_enable = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("rst pre inflight accepts", 32'(acc_count), 32'd3);
        rst_i       = 1'b1;
        hash_enable = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_i = 1'b0;
        q.delete();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst found", 32'(found), 32'd0);
        chk("rst found_nonce", 32'(found_nonce), 32'd0);
        chk("rst hash_count", 32'(hash_count), 32'd0);
        chk("rst core_valid", 32'(bus.core_valid), 32'd0);
        chk("rst core_nonce", 32'(bus.core_nonce), 32'd0);
        target        = 16'h0010;
        bus.res_valid = 1'b1;
        bus.res_hash  = '0;
        bus.res_nonce = 4'd7;
        @(posedge clk); @(negedge clk);
        bus.res_valid = 1'b0;
        chk("idle result hash_count", 32'(hash_count), 32'd0);
        chk("idle result found", 32'(found), 32'd0);
        $display("reset: busy=%0b hash_count=%0d found=%0b", busy, hash_count, found);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Backpressure: results withheld, pipeline fills to depth
        clear_model();
        target      = '0;
        hold        = 1'b1;
        hash_enable = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        chk("bp accepts at full", 32'(acc_count), 32'd4);
        chk("bp core_valid at full", 32'(bus.core_valid), 32'd0);
        rel_n = 1;
        for (int i = 0; i < 4; i++) cycle();
        chk("bp accepts after release", 32'(acc_count), 32'd5);
        chk("bp core_valid after release", 32'(bus.core_valid), 32'd0);
        chk("bp hash_count after release", 32'(hash_count), 32'd1);
        $display("backpressure: accepts=%0d hash_count=%0d", acc_count, hash_count);
        hold        = 1'b0;
        second_tick = 1'b1;
        for (int c = 0; c < 50 && !done; c++) cycle();
        chk("bp done", 32'(done), 32'd1);
        chk("bp final hash_count", 32'(hash_count), 32'd5);
        chk("bp final accepts", 32'(acc_count), 32'd5);
        hash_enable = 1'b0;
        cycle();
        chk("bp idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
